uart_echo_buffer: RTL

- Elastic byte buffer between the UART receiver (uart_rx) and transmitter (uart_tx2) in the loopback/echo path.
- Captures every received byte into a circular FIFO and drains it to the transmitter one byte at a time, waiting for each transmission to finish.
- Prevents bytes from being lost when the host sends back-to-back while the transmitter is busy.
- Exposes fill count and a sticky overflow flag for LED/debug pins.

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_echo_buffer.sv | 83 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and echo FSM state type
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_BAUD_DEFAULT = 9600;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } echo_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - circular FIFO with separate occupancy counter
module sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     pop_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_pop;
    logic                  do_push;

    assign empty    = (count == '0);
    assign full     = (count == CNT_DEPTH);
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    // When full, wr_ptr == rd_ptr: the head is read before the edge overwrites it.
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_buffer.sv
// rtl/uart_echo_buffer.sv - elastic byte buffer between uart_rx and uart_tx2
module uart_echo_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = UART_DATA_W
) (
    input  logic                ICE_CLK,
    input  logic                RST,
    input  logic                rx_dv,
    input  logic [DATA_W-1:0]   rx_byte,
    input  logic                tx_done,
    output logic                tx_dv,
    output logic [DATA_W-1:0]   tx_byte,
    output logic [DEPTH_LOG2:0] count,
    output logic                empty,
    output logic                full,
    output logic                overflow
);

    echo_state_t       state;
    logic              rx_dv_q;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    assign push = rx_dv && !rx_dv_q;
    assign pop  = (state == IDLE) && !empty;

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk       (ICE_CLK),
        .rst       (RST),
        .push      (push),
        .push_data (rx_byte),
        .pop       (pop),
        .pop_data  (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge ICE_CLK or posedge RST) begin
        if (RST) begin
            rx_dv_q  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rx_dv_q <= rx_dv;
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // tx_done is only honoured once the start strobe has dropped.
    always_ff @(posedge ICE_CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            tx_dv   <= 1'b0;
            tx_byte <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        tx_byte <= head;
                        tx_dv   <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    tx_dv <= 1'b0;
                    if (tx_done && !tx_dv) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
